mvd_expgolomb_decoder: RTL and testbench
========================================

// Module: mvd_expgolomb_decoder
// PURPOSE
//  Decoder-side counterpart of calc_mvd_cost. Consumes a serial bitstream holding one coded motion vector:
//  a 1-bit candidate index, then signed Exp-Golomb (se(v), order 0) mvd_x, then mvd_y.
//  Reconstructs the motion vector from the selected candidate, and reports the bits consumed.
//  The bit count equals the encoder-side bitcost, so the block also serves as a cross-check against calc_mvd_cost vectors.
// PARAMETERS
//  MAX_PREFIX  16  max leading-zero count per se(v) field; MAX_PREFIX+1 zeros is a syntax error
// PORTS
//  ap_clk           in   1   clock; all logic on rising edge
//  ap_rst_n         in   1   reset, asynchronous, active-low
//  ap_start         in   1   start pulse; sampled only when ap_idle=1
//  ap_idle          out  1   1 when ready to accept ap_start
//  mv_shift         in   32  MV precision shift; low 5 bits used, latched at accepted ap_start
//  mv_cand_0..3     in   16  signed candidates {x0,y0,x1,y1}, latched at accepted ap_start
//  bit_in           in   1   serial code bit, MSB-first per field
//  bit_in_vld       in   1   bit_in valid
//  bit_in_rdy       out  1   decoder accepts bit_in this cycle; transfer = vld & rdy
//  mv_x, mv_y       out  32  reconstructed MV, sign-extended; held until next mv_ap_vld
//  mv_ap_vld        out  1   one-cycle pulse: mv_x/mv_y/bitcount valid
//  bitcount         out  64  bits consumed for this MV
//  err_ap_vld       out  1   one-cycle pulse: prefix overflow, decode aborted
// BEHAVIOUR
//  Reset: all outputs 0 except ap_idle=1; state=IDLE; counters cleared. Reset mid-decode discards the partial result.
//  States: IDLE -> CAND -> PFX -> SFX -> (PFX for y | DONE) ; PFX -> ERR on overflow; DONE/ERR -> IDLE.
//   IDLE: ap_idle=1, bit_in_rdy=0. ap_start=1: latch inputs, clear bitcount, comp=X, go CAND.
//   CAND: rdy=1; accepted bit selects cand pair (0:{x0,y0}, 1:{x1,y1}); go PFX.
//   PFX: rdy=1; accepted 0 increments L. Accepted 1 goes to SFX (or directly to end of field if L=0).
//        If L would reach MAX_PREFIX+1: go ERR.
//   SFX: rdy=1; shift L accepted bits into info. After the L-th bit:
//        k = 2^L - 1 + info; mvd = k odd ? +(k+1)/2 : -(k/2).
//        comp=X: store mvd_x, comp=Y, go PFX. comp=Y: go DONE.
//   DONE: mv_ap_vld=1 for exactly one cycle; go IDLE.
//        mv_x = (mvd_x + cand_x) >>> shift; mv_y likewise (arithmetic shift; shift>=19 yields 0 or -1).
//   ERR: err_ap_vld=1 for one cycle; mv_* and bitcount keep prior values; go IDLE.
//  Latency: mv_ap_vld asserts the cycle after the last bit is accepted. Next ap_start is accepted the cycle after that.
//  bitcount = 1 + (2*Lx+1) + (2*Ly+1); counts accepted bits only. bit_in_vld gaps stall without state change.
//  ap_start while not idle is ignored. bit_in_vld in IDLE/DONE/ERR is not accepted (rdy=0).
//  Widths: k is MAX_PREFIX+1 bits unsigned; mvd is MAX_PREFIX+2 signed; sum is MAX_PREFIX+3 signed;
//   the sum of sign-extended cand and mvd is computed without overflow.
// STRUCTURE
//  mvd_dec_pkg: state enum (IDLE,CAND,PFX,SFX,DONE,ERR), comp enum, MAX_PREFIX default,
//   function se_map(k) -> signed mvd.
//  Sub-module eg_field_decoder: PFX/SFX counting plus se_map for one field, reused for x then y
//   with start/done/err handshake. Top holds the FSM, latches, reconstruction and bitcount.
// TESTING
//  1 shift=0, cand0=(5,0xFFFD), bits 0,1,1 -> mv=(0x5,0xFFFFFFFD), bitcount=3, mv_ap_vld 1 cycle after last bit.
//  2 shift=0, cand1=(0x10,0x20), bits 1,010,011 -> mvd=(+1,-1), mv=(0x11,0x1F), bitcount=7.
//  3 shift=2, cand0=(4,8), bits 0,00100,1 -> mvd=(+2,0), mv=(1,2), bitcount=7.
//  4 scenario 2 with bit_in_vld on alternate cycles -> identical outputs; no extra bits consumed.
//  5 bits 0 then 17 zeros -> err_ap_vld pulse, no mv_ap_vld, ap_idle=1 next cycle, rdy=0.
//  6 ap_rst_n low during SFX of mvd_y -> outputs 0, ap_idle=1; a following scenario 1 decodes correctly.

Source files
------------

// File: rtl/mvd_dec_pkg.sv
// Shared types, widths and arithmetic helpers for the motion-vector Exp-Golomb decoder.
package mvd_dec_pkg;

   localparam int unsigned MAX_PREFIX_DEF = 16;
   localparam int unsigned K_W     = MAX_PREFIX_DEF + 1;
   localparam int unsigned MVD_W   = MAX_PREFIX_DEF + 2;
   localparam int unsigned SUM_W   = MAX_PREFIX_DEF + 3;
   localparam int unsigned INFO_W  = MAX_PREFIX_DEF;
   localparam int unsigned LEN_W   = $clog2(MAX_PREFIX_DEF + 1);
   localparam int unsigned CAND_W  = 16;
   localparam int unsigned MV_W    = 32;
   localparam int unsigned BC_W    = 64;
   localparam int unsigned SHIFT_W = 5;
   localparam int unsigned BITS_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAND,
      ST_PFX,
      ST_SFX,
      ST_DONE,
      ST_ERR
   } state_t;

   typedef enum logic {
      COMP_X,
      COMP_Y
   } comp_t;

   // Map an unsigned code number onto the signed se(v) value: odd -> positive, even -> negative.
   function automatic logic [MVD_W-1:0] se_map(input logic [K_W-1:0] k);
      logic [MVD_W-1:0] w_ext;
      w_ext = {1'b0, k};
      if (k[0]) se_map = (w_ext + MVD_W'(1)) >> 1;
      else      se_map = MVD_W'(0) - (w_ext >> 1);
   endfunction

   // Candidate plus mvd, sign-extended wide enough not to overflow, then arithmetic shift.
   function automatic logic [MV_W-1:0] recon(input logic [CAND_W-1:0]  cand,
                                             input logic [MVD_W-1:0]   mvd,
                                             input logic [SHIFT_W-1:0] shift);
      logic [SUM_W-1:0]       w_sum;
      logic signed [MV_W-1:0] w_ext;
      w_sum = {{(SUM_W-CAND_W){cand[CAND_W-1]}}, cand} +
              {{(SUM_W-MVD_W){mvd[MVD_W-1]}}, mvd};
      w_ext = $signed({{(MV_W-SUM_W){w_sum[SUM_W-1]}}, w_sum});
      recon = w_ext >>> shift;
   endfunction

endpackage

// File: rtl/eg_field_decoder.sv
// Decodes one signed order-0 Exp-Golomb field from accepted serial bits; reused for x then y.
module eg_field_decoder
   import mvd_dec_pkg::*;
#(
   parameter int unsigned MAX_PREFIX = MAX_PREFIX_DEF
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_acc,
   input  logic             i_bit,
   output logic             o_done_c,
   output logic             o_err_c,
   output logic [MVD_W-1:0] o_mvd_c
);

   state_t              r_phase;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_cnt;
   logic [INFO_W-1:0]   r_info;

   logic                w_pfx;
   logic                w_last_sfx;
   logic [INFO_W-1:0]   w_info_nxt;
   logic [K_W-1:0]      w_k;

   // Result is formed combinationally on the accepting cycle so the caller can register it at once.
   always_comb begin
      w_pfx      = (r_phase == ST_PFX);
      w_info_nxt = {r_info[INFO_W-2:0], i_bit};
      w_last_sfx = !w_pfx && (r_cnt == (r_len - LEN_W'(1)));
      w_k        = w_pfx ? '0 : ((K_W'(1) << r_len) - K_W'(1) + K_W'(w_info_nxt));
      o_done_c   = i_acc && (w_pfx ? (i_bit && (r_len == '0)) : w_last_sfx);
      o_err_c    = i_acc && w_pfx && !i_bit && (r_len == LEN_W'(MAX_PREFIX));
      o_mvd_c    = se_map(w_k);
   end

   // Prefix zero counting, then suffix collection; self-clears after each field or an overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase <= ST_PFX;
         r_len   <= '0;
         r_cnt   <= '0;
         r_info  <= '0;
      end else if (i_start || o_done_c || o_err_c) begin
         r_phase <= ST_PFX;
         r_len   <= '0;
         r_cnt   <= '0;
         r_info  <= '0;
      end else if (i_acc) begin
         if (w_pfx) begin
            if (i_bit) begin
               r_phase <= ST_SFX;
               r_cnt   <= '0;
               r_info  <= '0;
            end else begin
               r_len <= r_len + LEN_W'(1);
            end
         end else begin
            r_info <= w_info_nxt;
            r_cnt  <= r_cnt + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/mvd_expgolomb_decoder.sv
// Serial motion-vector decoder: candidate select bit, then se(v) mvd_x and mvd_y, then reconstruction.
module mvd_expgolomb_decoder
   import mvd_dec_pkg::*;
#(
   parameter int unsigned MAX_PREFIX = MAX_PREFIX_DEF
)
(
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        ap_start,
   output logic        ap_idle,
   input  logic [31:0] mv_shift,
   input  logic [15:0] mv_cand_0,
   input  logic [15:0] mv_cand_1,
   input  logic [15:0] mv_cand_2,
   input  logic [15:0] mv_cand_3,
   input  logic        bit_in,
   input  logic        bit_in_vld,
   output logic        bit_in_rdy,
   output logic [31:0] mv_x,
   output logic [31:0] mv_y,
   output logic        mv_ap_vld,
   output logic [63:0] bitcount,
   output logic        err_ap_vld
);

   state_t                     r_state;
   comp_t                      r_comp;
   logic [SHIFT_W-1:0]         r_shift;
   logic [3:0][CAND_W-1:0]     r_cand;
   logic                       r_sel;
   logic [MVD_W-1:0]           r_mvd_x;
   logic [BITS_W-1:0]          r_bits;

   logic                       w_acc;
   logic                       w_start;
   logic                       w_fd_acc;
   logic                       w_fd_done;
   logic                       w_fd_err;
   logic [MVD_W-1:0]           w_fd_mvd;
   logic [CAND_W-1:0]          w_cand_x;
   logic [CAND_W-1:0]          w_cand_y;
   logic                       w_unused_shift;

   assign w_acc          = bit_in_vld && bit_in_rdy;
   assign w_start        = ap_start && ap_idle;
   assign w_fd_acc       = w_acc && (r_state == ST_PFX);
   assign w_cand_x       = r_sel ? r_cand[2] : r_cand[0];
   assign w_cand_y       = r_sel ? r_cand[3] : r_cand[1];
   assign w_unused_shift = ^mv_shift[31:SHIFT_W];

   eg_field_decoder #(
      .MAX_PREFIX (MAX_PREFIX)
   ) u_field (
      .i_clk    (ap_clk),
      .i_rst_n  (ap_rst_n),
      .i_start  (w_start),
      .i_acc    (w_fd_acc),
      .i_bit    (bit_in),
      .o_done_c (w_fd_done),
      .o_err_c  (w_fd_err),
      .o_mvd_c  (w_fd_mvd)
   );

   // Sequencing of select bit and both fields; ST_PFX covers a whole field, suffix phase lives in u_field.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state    <= ST_IDLE;
         r_comp     <= COMP_X;
         r_shift    <= '0;
         r_cand     <= '0;
         r_sel      <= 1'b0;
         r_mvd_x    <= '0;
         r_bits     <= '0;
         ap_idle    <= 1'b1;
         bit_in_rdy <= 1'b0;
         mv_x       <= '0;
         mv_y       <= '0;
         mv_ap_vld  <= 1'b0;
         bitcount   <= '0;
         err_ap_vld <= 1'b0;
      end else begin
         mv_ap_vld  <= 1'b0;
         err_ap_vld <= 1'b0;
         if (w_acc) r_bits <= r_bits + BITS_W'(1);
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_shift    <= mv_shift[SHIFT_W-1:0];
                  r_cand     <= {mv_cand_3, mv_cand_2, mv_cand_1, mv_cand_0};
                  r_bits     <= '0;
                  r_comp     <= COMP_X;
                  ap_idle    <= 1'b0;
                  bit_in_rdy <= 1'b1;
                  r_state    <= ST_CAND;
               end
            end
            ST_CAND: begin
               if (w_acc) begin
                  r_sel   <= bit_in;
                  r_state <= ST_PFX;
               end
            end
            ST_PFX: begin
               if (w_fd_err) begin
                  err_ap_vld <= 1'b1;
                  bit_in_rdy <= 1'b0;
                  r_state    <= ST_ERR;
               end else if (w_fd_done) begin
                  if (r_comp == COMP_X) begin
                     r_mvd_x <= w_fd_mvd;
                     r_comp  <= COMP_Y;
                  end else begin
                     mv_x       <= recon(w_cand_x, r_mvd_x, r_shift);
                     mv_y       <= recon(w_cand_y, w_fd_mvd, r_shift);
                     bitcount   <= BC_W'(r_bits) + BC_W'(1);
                     mv_ap_vld  <= 1'b1;
                     bit_in_rdy <= 1'b0;
                     r_state    <= ST_DONE;
                  end
               end
            end
            ST_DONE, ST_ERR: begin
               ap_idle <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               ap_idle    <= 1'b1;
               bit_in_rdy <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mvd_expgolomb_decoder.sv
// Self-checking bench: bitstreams are built by an se(v) encoder model and results predicted arithmetically.
module tb_mvd_expgolomb_decoder;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        ap_start = 1'b0;
   logic        ap_idle;
   logic [31:0] mv_shift = '0;
   logic [15:0] mv_cand_0 = '0, mv_cand_1 = '0, mv_cand_2 = '0, mv_cand_3 = '0;
   logic        bit_in = 1'b0;
   logic        bit_in_vld = 1'b0;
   logic        bit_in_rdy;
   logic [31:0] mv_x, mv_y;
   logic        mv_ap_vld;
   logic [63:0] bitcount;
   logic        err_ap_vld;

   mvd_expgolomb_decoder dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .ap_start   (ap_start),
      .ap_idle    (ap_idle),
      .mv_shift   (mv_shift),
      .mv_cand_0  (mv_cand_0),
      .mv_cand_1  (mv_cand_1),
      .mv_cand_2  (mv_cand_2),
      .mv_cand_3  (mv_cand_3),
      .bit_in     (bit_in),
      .bit_in_vld (bit_in_vld),
      .bit_in_rdy (bit_in_rdy),
      .mv_x       (mv_x),
      .mv_y       (mv_y),
      .mv_ap_vld  (mv_ap_vld),
      .bitcount   (bitcount),
      .err_ap_vld (err_ap_vld)
   );

   always #5 ap_clk = ~ap_clk;

   int cyc = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          is_err;
      logic [31:0] mx;
      logic [31:0] my;
      logic [63:0] bc;
   } exp_t;

   exp_t        exp_q[$];
   bit          bits_q[$];
   int          exp_cyc = -1;
   int          done_cnt = 0;
   bit          post_chk = 1'b0;
   logic [31:0] prev_x = '0, prev_y = '0;
   logic [63:0] prev_bc = '0;

   // se(v) code number and prefix length from plain arithmetic
   function automatic int code_num(input int v);
      return (v > 0) ? (2 * v - 1) : (-2 * v);
   endfunction

   function automatic int eg_len(input int v);
      int k1;
      int l;
      k1 = code_num(v) + 1;
      l = 0;
      while ((k1 >> (l + 1)) != 0) l++;
      return l;
   endfunction

   function automatic void enc(input int v);
      int k1;
      int l;
      k1 = code_num(v) + 1;
      l = eg_len(v);
      for (int i = 0; i < l; i++) bits_q.push_back(1'b0);
      for (int i = l; i >= 0; i--) bits_q.push_back(bit'((k1 >> i) & 1));
   endfunction

   function automatic logic [31:0] mv_model(input logic [15:0] c, input int mvd, input int sh);
      int s;
      s = int'($signed(c)) + mvd;
      return 32'(s >>> sh);
   endfunction

   // Checks every output pulse against the expectation queue and the cycle after it.
   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst_n) begin
         post_chk = 1'b0;
      end else begin
         if (post_chk) begin
            post_chk = 1'b0;
            chk("pulse_one_cycle", {62'd0, mv_ap_vld, err_ap_vld}, 64'd0);
            chk("idle_after_pulse", ap_idle, 1);
            chk("rdy_after_pulse", bit_in_rdy, 0);
         end
         if (mv_ap_vld || err_ap_vld) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {mv_ap_vld, err_ap_vld}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_latency", cyc, exp_cyc);
               chk("pulse_kind", {mv_ap_vld, err_ap_vld}, e.is_err ? 2'b01 : 2'b10);
               chk("rdy_during_pulse", bit_in_rdy, 0);
               if (e.is_err) begin
                  chk("err_keeps_mv_x", mv_x, prev_x);
                  chk("err_keeps_mv_y", mv_y, prev_y);
                  chk("err_keeps_bitcount", bitcount, prev_bc);
               end else begin
                  chk("mv_x", mv_x, e.mx);
                  chk("mv_y", mv_y, e.my);
                  chk("bitcount", bitcount, e.bc);
                  prev_x  = e.mx;
                  prev_y  = e.my;
                  prev_bc = e.bc;
               end
            end
            post_chk = 1'b1;
            done_cnt++;
         end
      end
   end

   // Start a decode and stream bits_q; gap inserts an idle cycle (with a stray ap_start) before each bit.
   task automatic send(input logic [4:0] sh, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d, input bit gap);
      for (int i = 0; i < 20 && !ap_idle; i++) @(negedge ap_clk);
      chk("idle_before_start", ap_idle, 1);
      mv_shift  = {27'h5555555, sh};
      mv_cand_0 = a;
      mv_cand_1 = b;
      mv_cand_2 = c;
      mv_cand_3 = d;
      ap_start  = 1'b1;
      @(negedge ap_clk);
      ap_start  = 1'b0;
      mv_shift  = 32'hFFFF_FFFF;
      mv_cand_0 = ~a;
      mv_cand_1 = ~b;
      mv_cand_2 = ~c;
      mv_cand_3 = ~d;
      for (int i = 0; i < bits_q.size(); i++) begin
         if (gap) begin
            bit_in_vld = 1'b0;
            bit_in     = ~bits_q[i];
            ap_start   = 1'b1;
            @(negedge ap_clk);
            ap_start   = 1'b0;
         end
         bit_in     = bits_q[i];
         bit_in_vld = 1'b1;
         chk("rdy_while_decoding", bit_in_rdy, 1);
         if (i == bits_q.size() - 1) exp_cyc = cyc + 1;
         @(negedge ap_clk);
      end
      bit_in_vld = 1'b0;
   endtask

   task automatic wait_done(input int start_cnt);
      for (int i = 0; i < 40 && done_cnt == start_cnt; i++) @(negedge ap_clk);
      chk("pulse_timeout", done_cnt != start_cnt, 1);
      @(negedge ap_clk);
      @(negedge ap_clk);
   endtask

   task automatic run_vec(input int sh, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input bit sel, input int mx, input int my, input bit gap);
      int n;
      bits_q.delete();
      bits_q.push_back(sel);
      enc(mx);
      enc(my);
      exp_q.push_back('{is_err: 1'b0,
                        mx: mv_model(sel ? c : a, mx, sh),
                        my: mv_model(sel ? d : b, my, sh),
                        bc: 64'(3 + 2 * eg_len(mx) + 2 * eg_len(my))});
      n = done_cnt;
      send(5'(sh), a, b, c, d, gap);
      wait_done(n);
   endtask

   task automatic run_err(input bit sel, input int pre_mvd);
      int n;
      bits_q.delete();
      bits_q.push_back(sel);
      if (pre_mvd != 0) enc(pre_mvd);
      for (int i = 0; i < 17; i++) bits_q.push_back(1'b0);
      exp_q.push_back('{is_err: 1'b1, mx: '0, my: '0, bc: '0});
      n = done_cnt;
      send(5'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
      wait_done(n);
   endtask

   function automatic logic [6:0] pack7();
      logic [6:0] pk;
      pk = '0;
      for (int i = 0; i < bits_q.size(); i++) pk = {pk[5:0], bits_q[i]};
      return pk;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end on its own");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge ap_clk);
      chk("rst_idle", ap_idle, 1);
      chk("rst_rdy", bit_in_rdy, 0);
      chk("rst_mv_x", mv_x, 0);
      chk("rst_mv_y", mv_y, 0);
      chk("rst_bitcount", bitcount, 0);
      chk("rst_pulses", {mv_ap_vld, err_ap_vld}, 0);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);

      // 1: zero mvds on candidate 0
      run_vec(0, 16'd5, 16'hFFFD, 16'h0, 16'h0, 1'b0, 0, 0, 1'b0);
      chk("t1_mv_x_lit", mv_x, 32'h5);
      chk("t1_mv_y_lit", mv_y, 32'hFFFF_FFFD);
      chk("t1_bitcount_lit", bitcount, 64'd3);

      // 2: candidate 1, mvd (+1,-1)
      run_vec(0, 16'h0, 16'h0, 16'h10, 16'h20, 1'b1, 1, -1, 1'b0);
      chk("t2_stream_lit", pack7(), 7'b1010011);
      chk("t2_mv_x_lit", mv_x, 32'h11);
      chk("t2_mv_y_lit", mv_y, 32'h1F);
      chk("t2_bitcount_lit", bitcount, 64'd7);

      // 3: shift 2, mvd (+2,0)
      run_vec(2, 16'd4, 16'd8, 16'h0, 16'h0, 1'b0, 2, 0, 1'b0);
      chk("t3_stream_lit", pack7(), 7'b0001001);
      chk("t3_mv_x_lit", mv_x, 32'd1);
      chk("t3_mv_y_lit", mv_y, 32'd2);
      chk("t3_bitcount_lit", bitcount, 64'd7);

      // 4: scenario 2 with valid gaps and ignored ap_start
      run_vec(0, 16'h0, 16'h0, 16'h10, 16'h20, 1'b1, 1, -1, 1'b1);
      chk("t4_mv_x_lit", mv_x, 32'h11);
      chk("t4_bitcount_lit", bitcount, 64'd7);

      // Maximum prefix length in both fields and extreme candidates
      run_vec(0, 16'h7FFF, 16'h8000, 16'h0, 16'h0, 1'b0, 65535, -65535, 1'b0);
      chk("maxpfx_mv_x_lit", mv_x, 32'h0001_7FFE);
      chk("maxpfx_bitcount_lit", bitcount, 64'd67);
      // Large and full shifts
      run_vec(20, 16'h0, 16'h0, 16'h8000, 16'h7FFF, 1'b1, -3, 100, 1'b0);
      run_vec(31, 16'hFFFF, 16'h1234, 16'h0, 16'h0, 1'b0, -5, 9, 1'b0);
      run_vec(3, 16'h0123, 16'hFF00, 16'h0, 16'h0, 1'b0, -7, 12, 1'b1);
      run_vec(1, 16'h0, 16'h0, 16'hFFF0, 16'h0010, 1'b1, 300, -1000, 1'b0);

      // 5: prefix overflow in x, then in y after a valid x
      run_err(1'b0, 0);
      run_err(1'b1, -1);
      run_vec(0, 16'h0040, 16'h0050, 16'h0, 16'h0, 1'b0, 4, -4, 1'b0);

      // 6: reset during the y suffix
      bits_q.delete();
      bits_q.push_back(1'b1);
      enc(1);
      bits_q.push_back(1'b0);
      bits_q.push_back(1'b1);
      send(5'd0, 16'h0, 16'h0, 16'h10, 16'h20, 1'b0);
      chk("mid_decode_rdy", bit_in_rdy, 1);
      ap_rst_n = 1'b0;
      #1;
      chk("arst_mv_x", mv_x, 0);
      chk("arst_mv_y", mv_y, 0);
      chk("arst_bitcount", bitcount, 0);
      chk("arst_idle", ap_idle, 1);
      chk("arst_rdy", bit_in_rdy, 0);
      chk("arst_pulses", {mv_ap_vld, err_ap_vld}, 0);
      prev_x  = '0;
      prev_y  = '0;
      prev_bc = '0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      run_vec(0, 16'd5, 16'hFFFD, 16'h0, 16'h0, 1'b0, 0, 0, 1'b0);
      chk("t6_mv_x_lit", mv_x, 32'h5);
      chk("t6_mv_y_lit", mv_y, 32'hFFFF_FFFD);
      chk("t6_bitcount_lit", bitcount, 64'd3);

      chk("pending_expectations", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
